// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared types, width defaults and keep-mask helper for the Huffman output packer
package huff_pkg;

  localparam int IN_WIDTH_DEF  = 128;
  localparam int OUT_WIDTH_DEF = 32;
  localparam int MAX_KEEP      = 64;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Upper ceil(fill/8) of nbytes lanes set; lanes above nbytes stay clear.
  function automatic logic [MAX_KEEP-1:0] keep_mask(input int fill, input int nbytes);
    int used;
    keep_mask = '0;
    used = (fill + 7) / 8;
    for (int i = 0; i < MAX_KEEP; i++) begin
      if ((i < nbytes) && (i >= nbytes - used)) keep_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/huff_align_shift.sv
// rtl/huff_align_shift.sv - masks a code word to its length and places it at a bit offset in the accumulator
module huff_align_shift #(
  parameter int IN_WIDTH   = 128,
  parameter int OUT_WIDTH  = 32,
  parameter int LEN_WIDTH  = $clog2(IN_WIDTH) + 1,
  parameter int FILL_WIDTH = $clog2(IN_WIDTH + OUT_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]           data,
  input  logic [LEN_WIDTH-1:0]          len,
  input  logic [FILL_WIDTH-1:0]         offset,
  output logic [IN_WIDTH+OUT_WIDTH-1:0] placed
);

  logic [IN_WIDTH-1:0] tail_mask;
  logic [IN_WIDTH-1:0] masked;

  // Ones below the valid code bits; len = 0 clears the whole word.
  assign tail_mask = {IN_WIDTH{1'b1}} >> len;
  assign masked    = data & ~tail_mask;
  assign placed    = {masked, {OUT_WIDTH{1'b0}}} >> offset;

endmodule

// File: rtl/huff_bitpack.sv
// rtl/huff_bitpack.sv - packs MSB-aligned variable-length code words into fixed-width output words
module huff_bitpack
  import huff_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int LEN_WIDTH = $clog2(IN_WIDTH) + 1,
  parameter int BUF_WIDTH = IN_WIDTH + OUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [LEN_WIDTH-1:0]   in_len,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [OUT_WIDTH/8-1:0] out_keep,
  output logic                   out_last,
  output logic [31:0]            pkt_bits
);

  localparam int FILL_WIDTH = $clog2(BUF_WIDTH);
  localparam int KEEP_WIDTH = OUT_WIDTH / 8;
  localparam logic [FILL_WIDTH-1:0] OUT_W = FILL_WIDTH'(OUT_WIDTH);

  state_t                  state;
  logic [BUF_WIDTH-1:0]    acc;
  logic [FILL_WIDTH-1:0]   fill;

  logic                    in_fire;
  logic                    out_fire;
  logic                    word_full;
  logic [FILL_WIDTH-1:0]   out_take;
  logic [FILL_WIDTH-1:0]   fill_base;
  logic [FILL_WIDTH-1:0]   in_add;
  logic [BUF_WIDTH-1:0]    acc_base;
  logic [BUF_WIDTH-1:0]    placed;
  logic [BUF_WIDTH-1:0]    acc_next;
  logic [FILL_WIDTH-1:0]   fill_next;
  logic [KEEP_WIDTH-1:0]   keep_part;
  logic [32:0]             pkt_sum;

  assign word_full = (fill >= OUT_W);
  assign in_ready  = (state == RUN) && (fill < OUT_W);
  assign out_valid = word_full || (state == FLUSH);
  assign out_data  = acc[BUF_WIDTH-1 -: OUT_WIDTH];
  assign keep_part = KEEP_WIDTH'(keep_mask(int'(fill), KEEP_WIDTH));
  assign out_keep  = ((state == RUN) || word_full) ? {KEEP_WIDTH{1'b1}} : keep_part;
  assign out_last  = (state == FLUSH) && (fill <= OUT_W);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // A padded word takes every remaining bit; shifting by a full word clears them too.
  assign out_take  = !out_fire ? '0 : (word_full ? OUT_W : fill);
  assign fill_base = fill - out_take;
  assign acc_base  = out_fire ? (acc << OUT_WIDTH) : acc;
  assign in_add    = in_fire ? FILL_WIDTH'(in_len) : '0;
  assign acc_next  = acc_base | (in_fire ? placed : '0);
  assign fill_next = fill_base + in_add;
  assign pkt_sum   = {1'b0, pkt_bits} + 33'(in_len);

  huff_align_shift #(
    .IN_WIDTH   (IN_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .FILL_WIDTH (FILL_WIDTH)
  ) u_align (
    .data   (in_data),
    .len    (in_len),
    .offset (fill_base),
    .placed (placed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      acc      <= '0;
      fill     <= '0;
      pkt_bits <= '0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
      case (state)
        RUN:     if (in_fire && in_last) state <= FLUSH;
        FLUSH:   if (out_fire && out_last) state <= RUN;
        default: state <= RUN;
      endcase
      if (out_fire && out_last) begin
        pkt_bits <= '0;
      end else if (in_fire) begin
        pkt_bits <= pkt_sum[32] ? 32'hFFFF_FFFF : pkt_sum[31:0];
      end
    end
  end

endmodule

// File: tb/tb_huff_bitpack.sv
// tb/tb_huff_bitpack.sv - self-checking bench for huff_bitpack against a bit-queue reference model
module tb_huff_bitpack;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [7:0]   in_len = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic [3:0]   out_keep;
  logic         out_last;
  logic [31:0]  pkt_bits;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t  expq[$];
  word_t  obs[$];
  bit     bq[$];
  longint model_pkt = 0;
  int     total = 0;
  int     bad = 0;
  int     bp_mode = 0;

  huff_bitpack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .pkt_bits  (pkt_bits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Pops up to 32 bits from the stream, MSB first, zero-padding what is missing.
  function automatic void push_word(input bit is_last);
    word_t w;
    int n;
    int nb;
    n = (bq.size() < 32) ? bq.size() : 32;
    w.data = '0;
    for (int j = 0; j < n; j++) w.data[31-j] = bq.pop_front();
    nb = (n + 7) / 8;
    w.keep = 4'(((1 << nb) - 1) << (4 - nb));
    w.last = is_last;
    expq.push_back(w);
  endfunction

  function automatic void model_accept(input logic [127:0] d, input int len, input bit last);
    for (int i = 0; i < len; i++) bq.push_back(d[127-i]);
    model_pkt = model_pkt + len;
    if (model_pkt > 64'hFFFF_FFFF) model_pkt = 64'hFFFF_FFFF;
    if (!last) begin
      while (bq.size() >= 32) push_word(1'b0);
    end else begin
      while (bq.size() > 32) push_word(1'b0);
      push_word(1'b1);
    end
  endfunction

  function automatic void model_clear();
    expq.delete();
    bq.delete();
    obs.delete();
    model_pkt = 0;
  endfunction

  // Entered and left at a falling edge; handshakes are judged just before the rising edge.
  task automatic step(output bit accepted);
    logic [127:0] d;
    int           l;
    bit           lst;
    bit           ofire;
    bit           clr;
    word_t        e;
    word_t        o;
    clr = 1'b0;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    #1;
    ofire = out_valid && out_ready;
    if (ofire) begin
      o.data = out_data;
      o.keep = out_keep;
      o.last = out_last;
      obs.push_back(o);
      check("word_expected", expq.size() != 0, 1'b1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("out_data", out_data, e.data);
        check("out_keep", out_keep, e.keep);
        check("out_last", out_last, e.last);
        clr = e.last;
      end
    end
    accepted = in_valid && in_ready;
    d = in_data;
    l = int'(in_len);
    lst = in_last;
    @(posedge clk);
    if (accepted) model_accept(d, l, lst);
    if (clr) model_pkt = 0;
    @(negedge clk);
    check("pkt_bits", pkt_bits, model_pkt[31:0]);
  endtask

  task automatic send(input logic [127:0] d, input int len, input bit last);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_len = 8'(len);
    in_last = last;
    while (!a && n < 300) begin
      step(a);
      n++;
    end
    check("send_accepted", a, 1'b1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while (n < 500 && !(expq.size() == 0 && !out_valid && in_ready)) begin
      step(a);
      n++;
    end
    check("drain_empty", expq.size(), 0);
    check("drain_idle", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic reset_midcycle();
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_pkt_bits", pkt_bits, 32'd0);
    check("rst_out_keep", out_keep, 4'hF);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit           a;
    logic [127:0] r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(a);
    reset_midcycle();

    // Two short codes forming one full word; low garbage must be masked.
    bp_mode = 0;
    r = rnd128();
    send({20'hABCDE, r[107:0]}, 20, 1'b0);
    r = rnd128();
    send({12'h123, r[115:0]}, 12, 1'b0);
    drain();
    check("two_in_count", obs.size(), 1);
    check("two_in_data", obs[0].data, 32'hABCDE123);
    check("two_in_keep", obs[0].keep, 4'hF);
    check("two_in_last", obs[0].last, 1'b0);
    check("two_in_pkt", pkt_bits, 32'd32);

    obs.delete();
    send(rnd128(), 0, 1'b1);
    drain();
    check("empty_count", obs.size(), 1);
    check("empty_data", obs[0].data, 32'd0);
    check("empty_keep", obs[0].keep, 4'h0);
    check("empty_last", obs[0].last, 1'b1);
    check("empty_pkt", pkt_bits, 32'd0);

    obs.delete();
    send(128'h00112233445566778899AABBCCDDEEFF, 128, 1'b1);
    drain();
    check("full_count", obs.size(), 4);
    check("full_w0", obs[0].data, 32'h00112233);
    check("full_w1", obs[1].data, 32'h44556677);
    check("full_w3", obs[3].data, 32'hCCDDEEFF);
    check("full_last2", obs[2].last, 1'b0);
    check("full_last3", obs[3].last, 1'b1);

    obs.delete();
    r = rnd128();
    send({13'b1010101010101, r[114:0]}, 13, 1'b1);
    check("last_latency", out_valid, 1'b1);
    drain();
    check("pad_data", obs[0].data, 32'hAAA80000);
    check("pad_keep", obs[0].keep, 4'b1100);
    check("pad_last", obs[0].last, 1'b1);

    // Backpressure in FLUSH with 40 bits held.
    obs.delete();
    bp_mode = 2;
    r = rnd128();
    send({40'hDEADBEEF5A, r[87:0]}, 40, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(a);
      check("bp_hold_data", out_data, 32'hDEADBEEF);
      check("bp_in_ready", in_ready, 1'b0);
    end
    bp_mode = 0;
    drain();
    check("bp_count", obs.size(), 2);
    check("bp_w0", obs[0].data, 32'hDEADBEEF);
    check("bp_w1", obs[1].data, 32'h5A000000);
    check("bp_keep1", obs[1].keep, 4'b1000);

    bp_mode = 2;
    r = rnd128();
    send({40'h0123456789, r[87:0]}, 40, 1'b1);
    step(a);
    check("bp2_valid", out_valid, 1'b1);
    reset_midcycle();
    bp_mode = 0;
    drain();

    // Random packets with random output backpressure.
    bp_mode = 1;
    for (int p = 0; p < 25; p++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        int  len;
        bit  lst;
        lst = (k == n - 1);
        len = $urandom_range(1, 128);
        if (lst && ($urandom_range(0, 4) == 0)) len = 0;
        send(rnd128(), len, lst);
        if ($urandom_range(0, 3) == 0) step(a);
      end
    end
    drain();
    bp_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huff_bitpack.md
# huff_bitpack

Output bit-packer for the Huffman encoder. Takes the variable-length, MSB-aligned code words produced by the concat stage and packs them into a dense stream of fixed-width output words with a valid/ready handshake. On the last input of a packet it flushes the remainder, zero-padded, with byte-keep and last markers. It sits directly downstream of the encoder's concat output and feeds the output FIFO or bus.

## Interface
- IN_WIDTH, 128, width of input code word (concat output width)
- OUT_WIDTH, 32, width of packed output word; multiple of 8, ≤ IN_WIDTH
- LEN_WIDTH, $clog2(IN_WIDTH)+1, width of in_len
- BUF_WIDTH, IN_WIDTH+OUT_WIDTH, internal accumulator width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  IN_WIDTH  code bits, MSB-aligned; bit IN_WIDTH-1 is first on the stream
- in_len  in  LEN_WIDTH  number of valid bits, 1..IN_WIDTH; 0 legal only with in_last
- in_last  in  1  final input of packet
- out_valid  out  1  output word present
- out_ready  in  1  output word consumed when out_valid & out_ready
- out_data  out  OUT_WIDTH  packed bits, MSB first
- out_keep  out  OUT_WIDTH/8  byte valid; out_keep[i] covers out_data[8i+7:8i]; valid bytes are always the upper ones
- out_last  out  1  final word of packet
- pkt_bits  out  32  count of valid bits accepted in the current packet; cleared on the out_last handshake

## Operation
- Accumulator `acc[BUF_WIDTH]`, left-justified; `fill` = number of valid bits held (0..BUF_WIDTH-1).
- States: RUN and FLUSH.
- RUN:
  - in_ready = (fill < OUT_WIDTH).
  - A handshake appends in_data[IN_WIDTH-1 -: in_len] directly after the current valid bits.
  - Bits below in_len in in_data are ignored and must be masked to zero before the append.
  - An accepted in_last moves the block to FLUSH.
- FLUSH:
  - in_ready = 0.
  - Full words are emitted while fill ≥ OUT_WIDTH.
  - When 0 < fill < OUT_WIDTH, one padded word is emitted: zero-filled below the valid bits, out_keep = upper ceil(fill/8) bytes set.
  - out_last is asserted on the word after which fill reaches 0.
  - Empty packet (fill = 0 on entry to FLUSH): emit one word with out_data = 0, out_keep = 0, out_last = 1.
  - The out_last handshake returns the block to RUN and clears pkt_bits.
- out_valid = (fill ≥ OUT_WIDTH) | (state == FLUSH).
  - In RUN, out_keep is all ones and out_last = 0.
- Output handshake: acc shifts left by OUT_WIDTH and fill decreases by OUT_WIDTH, or fill becomes 0 on the padded word.
- Simultaneous input and output handshakes (RUN, fill = OUT_WIDTH-k is impossible since in_ready requires fill < OUT_WIDTH; output fires only when fill ≥ OUT_WIDTH): never occur together in RUN. The RTL must still compute next fill as fill − out_take + in_len.
- pkt_bits adds in_len on each input handshake and saturates at 2^32−1.

## Timing
- Reset values: state = RUN, fill = 0, acc = 0, pkt_bits = 0, out_valid = 0, out_last = 0, out_keep = all ones, out_data = 0, in_ready = 1.
- Outputs are combinational from registers only. No combinational path exists from in_* to out_* or from out_ready to in_ready.
- Latency: an input accepted at edge k that brings fill to ≥ OUT_WIDTH gives out_valid high after edge k.
- Accepting in_last at edge k gives out_valid high after edge k.
- Throughput: one output word per cycle while fill ≥ OUT_WIDTH and out_ready = 1.
- While out_valid = 1 and out_ready = 0, out_data, out_keep and out_last hold stable.
- Reset asserted mid-packet (RUN or FLUSH) discards all state immediately. The next packet starts clean.

## Structure
- Shared package huff_pkg holds:
  - the state enum {RUN, FLUSH};
  - a function computing ceil(fill/8) → keep mask;
  - the default width constants.
- One sub-module: huff_align_shift. It is a combinational barrel shifter that places masked in_data at bit offset fill within BUF_WIDTH. All registers live in huff_bitpack.

## Test plan
- Reset: assert rst asynchronously mid-cycle → out_valid = 0, in_ready = 1, pkt_bits = 0, with no wait for clk.
- Two inputs, out_ready = 1:
  - stimulus: len 20 with top bits 0xABCDE, then len 12 with top bits 0x123;
  - response: one word 0xABCDE123, out_keep = 4'hF, out_last = 0, pkt_bits = 32.
- One input len 128, in_last = 1, data 0x0011…EEFF → four consecutive words 0x00112233 … 0xCCDDEEFF, out_last only on the 4th, then in_ready = 1.
- Len 13 last with top bits 1010101010101 → one word 0xAAA80000, out_keep = 4'b1100, out_last = 1.
- Empty packet: in_len = 0, in_last = 1, fill = 0 → one word out_data = 0, out_keep = 0, out_last = 1.
- Backpressure and reset in FLUSH:
  - hold out_ready = 0 for 10 cycles with fill = 40 → out_data stable and in_ready = 0;
  - release → word emitted, then the padded 8-bit word with keep 4'b1000;
  - repeat, asserting rst during FLUSH → all outputs return to reset values.
